// File: rtl/cve2_trace_pkg.sv
// rtl/cve2_trace_pkg.sv - shared types for the cve2 RVFI trace buffer
package cve2_trace_pkg;

   typedef struct packed {
      logic [15:0] order;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic        trap;
      logic        intr;
   } trace_rec_t;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_ALL    = 2'b01,
      MODE_EXC    = 2'b10,
      MODE_WINDOW = 2'b11
   } trace_mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      FROZEN = 2'b10
   } trace_state_e;

   // Inclusive unsigned window; an inverted window (lo > hi) matches nothing.
   function automatic logic pc_in_window(logic [31:0] pc, logic [31:0] lo, logic [31:0] hi);
      return (pc >= lo) && (pc <= hi);
   endfunction

endpackage

// File: rtl/cve2_trace_fifo.sv
// rtl/cve2_trace_fifo.sv - circular record store with drop or overwrite on full
module cve2_trace_fifo
   import cve2_trace_pkg::*;
#(
   parameter int unsigned Depth           = 8,
   parameter bit          OverwriteOnFull = 1'b0,
   localparam int unsigned PtrW           = $clog2(Depth),
   localparam int unsigned LvlW           = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            push_i,
   input  trace_rec_t      wdata_i,
   input  logic            pop_i,
   output trace_rec_t      rdata_o,
   output logic [LvlW-1:0] level_o,
   output logic            wr_o,
   output logic            drop_o
);

   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LvlW-1:0] level_q, level_d;
   trace_rec_t      mem_q [Depth];
   trace_rec_t      mem_d [Depth];

   logic full, pop, wr, ovr;

   assign full = (level_q == LvlW'(Depth));
   assign pop  = pop_i && (level_q != '0);
   // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
   assign wr   = push_i && (!full || pop || OverwriteOnFull);
   assign ovr  = push_i && full && !pop && OverwriteOnFull;

   assign wr_o    = wr && !clear_i;
   assign drop_o  = push_i && full && !pop && !clear_i;
   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (clear_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (wr) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + PtrW'(1);
         end
         if (pop || ovr) begin
            rptr_d = rptr_q + PtrW'(1);
         end
         unique case ({wr && !ovr, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// rtl/cve2_rvfi_trace_buffer.sv - filtered RVFI retirement capture with freeze and drain port
module cve2_rvfi_trace_buffer
   import cve2_trace_pkg::*;
#(
   parameter int unsigned Depth           = 8,
   parameter bit          OverwriteOnFull = 1'b0,
   parameter bit          FreezeOnTrap    = 1'b1,
   parameter int unsigned DropCntWidth    = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         rvfi_valid_i,
   input  logic [63:0]                  rvfi_order_i,
   input  logic [31:0]                  rvfi_insn_i,
   input  logic                         rvfi_trap_i,
   input  logic                         rvfi_intr_i,
   input  logic [31:0]                  rvfi_pc_rdata_i,
   input  logic [4:0]                   rvfi_rd_addr_i,
   input  logic [31:0]                  rvfi_rd_wdata_i,
   input  logic [1:0]                   mode_i,
   input  logic [31:0]                  pc_lo_i,
   input  logic [31:0]                  pc_hi_i,
   input  logic                         freeze_i,
   input  logic                         clear_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output trace_rec_t                   out_record_o,
   output logic [$clog2(Depth+1)-1:0]   level_o,
   output logic [DropCntWidth-1:0]      drop_cnt_o,
   output logic                         frozen_o
);

   trace_state_e            state_q, state_d;
   logic                    frozen_q;
   logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
   logic                    match, push_req, pop, wr, drop;
   trace_rec_t              rec;
   logic                    unused_order;

   assign unused_order = ^rvfi_order_i[63:16];

   always_comb begin
      match = 1'b0;
      unique case (mode_i)
         MODE_ALL:    match = 1'b1;
         MODE_EXC:    match = rvfi_trap_i | rvfi_intr_i;
         MODE_WINDOW: match = pc_in_window(rvfi_pc_rdata_i, pc_lo_i, pc_hi_i);
         default:     match = 1'b0;
      endcase
   end

   assign push_req = (state_q == RUN) && rvfi_valid_i && match;

   always_comb begin
      rec.order    = rvfi_order_i[15:0];
      rec.pc       = rvfi_pc_rdata_i;
      rec.insn     = rvfi_insn_i;
      rec.rd_addr  = rvfi_rd_addr_i;
      rec.rd_wdata = rvfi_rd_wdata_i;
      rec.trap     = rvfi_trap_i;
      rec.intr     = rvfi_intr_i;
   end

   assign out_valid_o = (level_o != '0);
   assign pop         = out_valid_o && out_ready_i;

   cve2_trace_fifo #(
      .Depth           (Depth),
      .OverwriteOnFull (OverwriteOnFull)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (push_req),
      .wdata_i (rec),
      .pop_i   (pop),
      .rdata_o (out_record_o),
      .level_o (level_o),
      .wr_o    (wr),
      .drop_o  (drop)
   );

   // Only a trap record that actually lands in the buffer triggers the freeze.
   always_comb begin
      state_d    = state_q;
      drop_cnt_d = drop_cnt_q;
      if (clear_i) begin
         state_d    = IDLE;
         drop_cnt_d = '0;
      end else begin
         if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DropCntWidth'(1);
         end
         unique case (state_q)
            IDLE:    if (mode_i != MODE_OFF) state_d = RUN;
            RUN: begin
               if (freeze_i || (FreezeOnTrap && wr && rvfi_trap_i)) state_d = FROZEN;
               else if (mode_i == MODE_OFF)                         state_d = IDLE;
            end
            FROZEN:  state_d = FROZEN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         frozen_q   <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         frozen_q   <= (state_d == FROZEN);
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign frozen_o   = frozen_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// tb/tb_cve2_rvfi_trace_buffer.sv - randomized and directed checks of the trace buffer
module tb_cve2_rvfi_trace_buffer;
   import cve2_trace_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, trap, intr, freeze, clear, ready;
   logic [63:0] order;
   logic [31:0] insn, pc, rd_wdata, pc_lo, pc_hi;
   logic [4:0]  rd_addr;
   logic [1:0]  mode;

   logic        out_valid [2];
   trace_rec_t  out_record [2];
   logic [3:0]  level [2];
   logic        frozen [2];
   logic [15:0] drop0;
   logic [3:0]  drop1;

   int tests = 0;
   int fails = 0;
   int ordc  = 0;

   trace_rec_t mq [2][$];
   trace_rec_t popped [2][$];
   int         mdrop [2] = '{0, 0};
   int         mst [2]   = '{0, 0};

   always #5 clk = ~clk;

   cve2_rvfi_trace_buffer dut0 (
      .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid), .rvfi_order_i(order),
      .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_pc_rdata_i(pc),
      .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(rd_wdata), .mode_i(mode), .pc_lo_i(pc_lo),
      .pc_hi_i(pc_hi), .freeze_i(freeze), .clear_i(clear), .out_valid_o(out_valid[0]),
      .out_ready_i(ready), .out_record_o(out_record[0]), .level_o(level[0]),
      .drop_cnt_o(drop0), .frozen_o(frozen[0])
   );

   cve2_rvfi_trace_buffer #(.OverwriteOnFull(1'b1), .DropCntWidth(4)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid), .rvfi_order_i(order),
      .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_pc_rdata_i(pc),
      .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(rd_wdata), .mode_i(mode), .pc_lo_i(pc_lo),
      .pc_hi_i(pc_hi), .freeze_i(freeze), .clear_i(clear), .out_valid_o(out_valid[1]),
      .out_ready_i(ready), .out_record_o(out_record[1]), .level_o(level[1]),
      .drop_cnt_o(drop1), .frozen_o(frozen[1])
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_match();
      case (mode)
         2'd1:    return 1'b1;
         2'd2:    return trap | intr;
         2'd3:    return (pc >= pc_lo) && (pc <= pc_hi);
         default: return 1'b0;
      endcase
   endfunction

   function automatic trace_rec_t cur_rec();
      trace_rec_t r;
      r.order = order[15:0]; r.pc = pc; r.insn = insn; r.rd_addr = rd_addr;
      r.rd_wdata = rd_wdata; r.trap = trap; r.intr = intr;
      return r;
   endfunction

   // State numbering here: 0 idle, 1 capturing, 2 frozen.
   task automatic model_step(input int k, input bit owf, input int dmax);
      bit pop, req, stored;
      pop = (mq[k].size() != 0) && ready;
      if (clear) begin
         mq[k].delete();
         mdrop[k] = 0;
         mst[k]   = 0;
      end else begin
         req    = (mst[k] == 1) && valid && model_match();
         stored = 1'b0;
         if (pop) void'(mq[k].pop_front());
         if (req) begin
            if (mq[k].size() < 8) begin
               mq[k].push_back(cur_rec());
               stored = 1'b1;
            end else begin
               if (owf) begin
                  void'(mq[k].pop_front());
                  mq[k].push_back(cur_rec());
                  stored = 1'b1;
               end
               if (mdrop[k] < dmax) mdrop[k]++;
            end
         end
         if (mst[k] == 0) begin
            if (mode != 2'd0) mst[k] = 1;
         end else if (mst[k] == 1) begin
            if (freeze || (stored && trap)) mst[k] = 2;
            else if (mode == 2'd0)          mst[k] = 0;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mdrop[k] = 0;
            mst[k]   = 0;
         end
      end else begin
         model_step(0, 1'b0, 65535);
         model_step(1, 1'b1, 15);
      end
   end

   always @(negedge clk) begin
      chk("drop0", 128'(drop0), 128'(mdrop[0]));
      chk("drop1", 128'(drop1), 128'(mdrop[1]));
      for (int k = 0; k < 2; k++) begin
         chk("valid", 128'(out_valid[k]), 128'(mq[k].size() != 0));
         chk("level", 128'(level[k]), 128'(mq[k].size()));
         chk("frozen", 128'(frozen[k]), 128'(mst[k] == 2));
         if (out_valid[k] && mq[k].size() != 0) chk("record", 128'(out_record[k]), 128'(mq[k][0]));
         if (out_valid[k] && ready) popped[k].push_back(out_record[k]);
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] p, input bit tr, input bit ir);
      cycle();
      valid = 1'b1; order = 64'(ordc) | 64'h1234_0000_0000_0000; ordc++;
      pc = p; insn = $urandom; rd_addr = 5'($urandom); rd_wdata = $urandom;
      trap = tr; intr = ir;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         cycle();
         valid = 1'b0; trap = 1'b0; intr = 1'b0; freeze = 1'b0; clear = 1'b0;
      end
   endtask

   task automatic start(input logic [1:0] m);
      cycle(); valid = 1'b0; clear = 1'b1; mode = 2'd0;
      cycle(); clear = 1'b0; mode = m;
      cycle();
      ordc = 0;
      popped[0].delete();
      popped[1].delete();
   endtask

   int e0 [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 10};

   initial begin
      rst_n = 1'b1; valid = 0; trap = 0; intr = 0; freeze = 0; clear = 0; ready = 0;
      order = 0; insn = 0; pc = 0; rd_wdata = 0; rd_addr = 0; mode = 0;
      pc_lo = 32'h200; pc_hi = 32'h20C;
      #1 rst_n = 1'b0;
      repeat (3) cycle();
      chk("rst_valid", 128'(out_valid[0]), 128'(0));
      chk("rst_level", 128'(level[0]), 128'(0));
      chk("rst_drop", 128'(drop0), 128'(0));
      chk("rst_frozen", 128'(frozen[0]), 128'(0));
      rst_n = 1'b1;

      // Three back-to-back retirements, drained as they arrive.
      start(2'd1); ready = 1'b1;
      retire(32'h100, 0, 0);
      retire(32'h104, 0, 0);
      chk("lat_valid", 128'(out_valid[0]), 128'(1));
      chk("lat_pc", 128'(out_record[0].pc), 128'(32'h100));
      retire(32'h108, 0, 0);
      idle(3);
      chk("s1_cnt", 128'(popped[0].size()), 128'(3));
      for (int i = 0; i < 3 && i < popped[0].size(); i++) begin
         chk("s1_order", 128'(popped[0][i].order), 128'(i));
         chk("s1_pc", 128'(popped[0][i].pc), 128'(32'h100 + 4 * i));
      end
      chk("s1_drop", 128'(drop0), 128'(0));

      // Ten retirements into an undrained buffer, then a push+pop while full.
      start(2'd1); ready = 1'b0;
      for (int i = 0; i < 10; i++) retire(32'h1000 + 32'(4 * i), 0, 0);
      idle(2);
      chk("full_lvl0", 128'(level[0]), 128'(8));
      chk("full_lvl1", 128'(level[1]), 128'(8));
      chk("full_drop0", 128'(drop0), 128'(2));
      chk("full_drop1", 128'(drop1), 128'(2));
      retire(32'h2000, 0, 0); ready = 1'b1;
      cycle(); valid = 1'b0; ready = 1'b0;
      idle(1);
      chk("pp_lvl0", 128'(level[0]), 128'(8));
      chk("pp_lvl1", 128'(level[1]), 128'(8));
      chk("pp_drop0", 128'(drop0), 128'(2));
      chk("pp_drop1", 128'(drop1), 128'(2));
      ready = 1'b1;
      idle(10);
      chk("dr_cnt0", 128'(popped[0].size()), 128'(9));
      chk("dr_cnt1", 128'(popped[1].size()), 128'(9));
      for (int i = 0; i < 9 && i < popped[0].size(); i++) chk("dr_ord0", 128'(popped[0][i].order), 128'(e0[i]));
      for (int i = 0; i < 9 && i < popped[1].size(); i++) chk("dr_ord1", 128'(popped[1][i].order), 128'(i + 2));

      // PC window filter.
      pc_lo = 32'h200; pc_hi = 32'h20C;
      start(2'd3); ready = 1'b0;
      retire(32'h1FC, 0, 0); retire(32'h200, 0, 0); retire(32'h20C, 0, 0); retire(32'h210, 0, 0);
      idle(2);
      chk("win_lvl", 128'(level[0]), 128'(2));
      ready = 1'b1;
      idle(4);
      chk("win_cnt", 128'(popped[0].size()), 128'(2));
      if (popped[0].size() == 2) begin
         chk("win_pc0", 128'(popped[0][0].pc), 128'(32'h200));
         chk("win_pc1", 128'(popped[0][1].pc), 128'(32'h20C));
      end

      // Freeze on trap, then clear.
      start(2'd1); ready = 1'b0;
      for (int i = 0; i < 3; i++) retire(32'h300 + 32'(4 * i), 0, 0);
      retire(32'h30C, 1, 0);
      retire(32'h310, 0, 0); retire(32'h314, 0, 0);
      idle(2);
      chk("frz_lvl", 128'(level[0]), 128'(4));
      chk("frz_flag0", 128'(frozen[0]), 128'(1));
      chk("frz_flag1", 128'(frozen[1]), 128'(1));
      cycle(); clear = 1'b1; mode = 2'd0;
      cycle(); clear = 1'b0;
      chk("clr_lvl", 128'(level[0]), 128'(0));
      chk("clr_frozen", 128'(frozen[0]), 128'(0));
      chk("clr_state", 128'(dut0.state_q == IDLE), 128'(1));

      // Reset in the middle of a drain.
      start(2'd1); ready = 1'b0;
      for (int i = 0; i < 5; i++) retire(32'h400 + 32'(4 * i), 0, 0);
      cycle(); valid = 1'b0; ready = 1'b1;
      cycle();
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 128'(out_valid[0]), 128'(0));
      chk("mrst_level", 128'(level[0]), 128'(0));
      chk("mrst_level1", 128'(level[1]), 128'(0));
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Random traffic checked cycle by cycle against the model.
      for (int n = 0; n < 4000; n++) begin
         cycle();
         valid = 1'($urandom_range(0, 1));
         order = {$urandom, $urandom}; insn = $urandom; rd_wdata = $urandom; rd_addr = 5'($urandom);
         pc = 32'h1F0 + 32'(4 * $urandom_range(0, 12));
         trap = ($urandom_range(0, 9) == 0);
         intr = ($urandom_range(0, 9) == 0);
         ready = ($urandom_range(0, 2) == 0);
         freeze = ($urandom_range(0, 99) == 0);
         clear = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) begin
            pc_lo = 32'h1F0 + 32'(4 * $urandom_range(0, 12));
            pc_hi = 32'h1F0 + 32'(4 * $urandom_range(0, 12));
         end
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
